display_scan_feeder: RTL and testbench

- Sits directly upstream of the anode driver and the segment decoder on the calculator's 4-digit 7-segment display.
- Converts the binary calculator result into four BCD digits using a sequential double-dabble FSM, one shift per clock.
- Generates the 2-bit `refreshcounter` that the anode driver consumes.
- Presents the BCD code of the currently scanned digit to the cathode decoder.

---
 rtl/display_scan_feeder.sv | 128 ++++++++++++
 tb/tb_display_scan_feeder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_feeder.sv
// Binary-to-BCD front end for a 4-digit multiplexed 7-segment display.
// Sequential double-dabble conversion, digit refresh counter and per-slot BCD select.
module display_scan_feeder #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [13:0] value_in,
  input  logic        load,
  output logic        busy,
  output logic        overflow,
  output logic [1:0]  refreshcounter,
  output logic [3:0]  digit_bcd
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [3:0] BLANK_CODE = 4'hA;
  localparam logic [3:0] DASH_CODE  = 4'hF;
  localparam logic [3:0] LEAD_RESET = BLANK_LZ ? BLANK_CODE : 4'h0;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t      state, state_next;
  logic [13:0] bin;
  logic [16:0] bcd;
  logic [15:0] bcd_adj;
  logic [3:0]  shift_cnt;
  logic        over_cap;
  logic        over_next;
  logic [3:0]  disp [4];
  logic [3:0]  commit_digit [4];
  logic        lead;
  logic [PW-1:0] presc;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (load) state_next = CONVERT;
      CONVERT: if (shift_cnt == 4'd13) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_comb begin
    bcd_adj = bcd[15:0];
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      bin       <= '0;
      bcd       <= '0;
      shift_cnt <= '0;
      over_cap  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (load) begin
          bin       <= value_in;
          bcd       <= '0;
          shift_cnt <= '0;
          over_cap  <= (value_in > 14'd9999);
        end
        CONVERT: begin
          {bcd, bin} <= {bcd_adj, bin, 1'b0};
          shift_cnt  <= shift_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Leading-zero blanking walks thousands->tens and stops at the first non-zero digit.
  always_comb begin
    over_next       = over_cap | bcd[16];
    commit_digit[0] = bcd[15:12];
    commit_digit[1] = bcd[11:8];
    commit_digit[2] = bcd[7:4];
    commit_digit[3] = bcd[3:0];
    lead            = BLANK_LZ;
    for (int unsigned i = 0; i < 3; i++) begin
      if (lead && commit_digit[i] == 4'h0) commit_digit[i] = BLANK_CODE;
      else                                 lead = 1'b0;
    end
    if (over_next) begin
      for (int unsigned i = 0; i < 4; i++) commit_digit[i] = DASH_CODE;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      disp[0]  <= LEAD_RESET;
      disp[1]  <= LEAD_RESET;
      disp[2]  <= LEAD_RESET;
      disp[3]  <= 4'h0;
      overflow <= 1'b0;
    end else if (state == COMMIT) begin
      for (int unsigned i = 0; i < 4; i++) disp[i] <= commit_digit[i];
      overflow <= over_next;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      presc          <= '0;
      refreshcounter <= '0;
    end else if (presc == PRESC_MAX) begin
      presc          <= '0;
      refreshcounter <= refreshcounter + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign digit_bcd = disp[refreshcounter];

endmodule

// File: tb/tb_display_scan_feeder.sv
// Scoreboard bench for display_scan_feeder: one DUT with blanking, one without.
// Expected digits come from a decimal divide/modulo model, not from double-dabble.
module tb_display_scan_feeder;

  localparam int RD = 4;

  typedef struct {
    logic [15:0] digits;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] value_in = '0;
  logic        load0 = 1'b0;
  logic        load1 = 1'b0;
  logic        busy_w [2];
  logic        ovf_w  [2];
  logic [1:0]  rc_w   [2];
  logic [3:0]  dig_w  [2];

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  display_scan_feeder #(.REFRESH_DIV(RD), .BLANK_LZ(1'b1)) dut (
    .clk_in(clk), .rst(rst), .value_in(value_in), .load(load0),
    .busy(busy_w[0]), .overflow(ovf_w[0]), .refreshcounter(rc_w[0]), .digit_bcd(dig_w[0])
  );

  display_scan_feeder #(.REFRESH_DIV(RD), .BLANK_LZ(1'b0)) dut_nb (
    .clk_in(clk), .rst(rst), .value_in(value_in), .load(load1),
    .busy(busy_w[1]), .overflow(ovf_w[1]), .refreshcounter(rc_w[1]), .digit_bcd(dig_w[1])
  );

  function automatic logic [15:0] model(input int v, input bit blank);
    logic [3:0] d [4];
    bit lead;
    if (v > 9999) return 16'hFFFF;
    d[0] = 4'(v / 1000);
    d[1] = 4'((v / 100) % 10);
    d[2] = 4'((v / 10) % 10);
    d[3] = 4'(v % 10);
    lead = blank;
    for (int i = 0; i < 3; i++) begin
      if (lead && d[i] == 4'h0) d[i] = 4'hA;
      else lead = 1'b0;
    end
    return {d[0], d[1], d[2], d[3]};
  endfunction

  function automatic logic [3:0] slot_of(input logic [15:0] digits, input logic [1:0] s);
    logic [15:0] t;
    t = digits >> (4 * (3 - int'(s)));
    return t[3:0];
  endfunction

  task automatic do_load(input int sel, input int v);
    value_in = 14'(v);
    if (sel == 1) load1 = 1'b1; else load0 = 1'b1;
    @(posedge clk); #1;
    load0 = 1'b0;
    load1 = 1'b0;
    checks++;
    if (busy_w[sel] !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise v=%0d: got %b expected 1", v, busy_w[sel]);
    end
    sb.push_back('{digits: model(v, sel == 0), ovf: (v > 9999)});
  endtask

  task automatic wait_commit(input int sel, input int start, input string name);
    int n;
    exp_t e;
    logic [3:0] seen [4];
    bit ovbad;
    n = start;
    while (busy_w[sel] === 1'b1 && n < 40) begin
      @(posedge clk); #1;
      if (busy_w[sel] === 1'b1) n++;
    end
    checks++;
    if (n != 15) begin
      errors++;
      $display("FAIL %s busy_len: got %0d expected 15", name, n);
      if (n >= 40) return;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty expected entry", name);
      return;
    end
    e = sb.pop_front();
    ovbad = 1'b0;
    for (int i = 0; i < 4; i++) seen[i] = 4'hx;
    for (int c = 0; c < 4 * RD; c++) begin
      seen[rc_w[sel]] = dig_w[sel];
      if (ovf_w[sel] !== e.ovf) ovbad = 1'b1;
      @(posedge clk); #1;
    end
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (seen[s] !== slot_of(e.digits, 2'(s))) begin
        errors++;
        $display("FAIL %s slot%0d: got %h expected %h", name, s, seen[s], slot_of(e.digits, 2'(s)));
      end
    end
    checks++;
    if (ovbad) begin
      errors++;
      $display("FAIL %s overflow: got %b expected %b", name, ovf_w[sel], e.ovf);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int presc, rc;
    logic [15:0] rd;
    rd = 16'hAAA0;
    apply_reset();
    presc = 0;
    rc = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (presc == RD - 1) begin presc = 0; rc = (rc + 1) % 4; end
      else presc++;
      checks++;
      if (rc_w[0] !== 2'(rc) || dig_w[0] !== slot_of(rd, 2'(rc))) begin
        errors++;
        $display("FAIL reset_scan c=%0d: got rc=%0d dig=%h expected rc=%0d dig=%h",
                 c, rc_w[0], dig_w[0], rc, slot_of(rd, 2'(rc)));
      end
      checks++;
      if (busy_w[0] !== 1'b0 || ovf_w[0] !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags c=%0d: got busy=%b ovf=%b expected 0 0", c, busy_w[0], ovf_w[0]);
      end
    end
    checks++;
    if (dig_w[1] !== 4'h0) begin
      errors++;
      $display("FAIL reset_noblank: got %h expected 0", dig_w[1]);
    end
  endtask

  task automatic test_convert();
    do_load(0, 1234);
    wait_commit(0, 1, "conv1234");
  endtask

  task automatic test_blanking();
    do_load(0, 7);
    wait_commit(0, 1, "blank7");
    do_load(0, 1005);
    wait_commit(0, 1, "interior1005");
    do_load(1, 7);
    wait_commit(1, 1, "noblank7");
  endtask

  task automatic test_overflow();
    do_load(0, 10000);
    wait_commit(0, 1, "ovf10000");
    do_load(0, 9999);
    wait_commit(0, 1, "max9999");
    do_load(0, 16383);
    wait_commit(0, 1, "ovf16383");
    do_load(0, 0);
    wait_commit(0, 1, "zero");
  endtask

  task automatic test_load_while_busy();
    do_load(0, 4321);
    repeat (4) begin @(posedge clk); #1; end
    value_in = 14'd8888;
    load0 = 1'b1;
    @(posedge clk); #1;
    load0 = 1'b0;
    wait_commit(0, 6, "busyignore");
    checks++;
    if (busy_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL busyignore_requeue: got busy=%b expected 0", busy_w[0]);
    end
    do_load(0, 8888);
    wait_commit(0, 1, "conv8888");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_load(0, 1111);
    repeat (14) begin @(posedge clk); #1; end
    value_in = 14'd2222;
    load0 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_fall: got busy=%b expected 0", busy_w[0]);
    end
    e = sb.pop_front();
    checks++;
    if (dig_w[0] !== slot_of(e.digits, rc_w[0])) begin
      errors++;
      $display("FAIL b2b_visible: got %h expected %h", dig_w[0], slot_of(e.digits, rc_w[0]));
    end
    value_in = 14'd3333;
    @(posedge clk); #1;
    load0 = 1'b0;
    checks++;
    if (busy_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b expected 1", busy_w[0]);
    end
    sb.push_back('{digits: model(3333, 1'b1), ovf: 1'b0});
    wait_commit(0, 1, "b2b3333");
  endtask

  task automatic test_reset_abort();
    logic [3:0] seen [4];
    logic [15:0] rd;
    rd = 16'hAAA0;
    do_load(0, 10000);
    wait_commit(0, 1, "preovf");
    do_load(0, 5678);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    #1;
    checks++;
    if (busy_w[0] !== 1'b0 || ovf_w[0] !== 1'b0 || rc_w[0] !== 2'd0 || dig_w[0] !== 4'hA) begin
      errors++;
      $display("FAIL abort_async: got busy=%b ovf=%b rc=%0d dig=%h expected 0 0 0 a",
               busy_w[0], ovf_w[0], rc_w[0], dig_w[0]);
    end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      seen[rc_w[0]] = dig_w[0];
      checks++;
      if (busy_w[0] !== 1'b0 || ovf_w[0] !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle c=%0d: got busy=%b ovf=%b expected 0 0", c, busy_w[0], ovf_w[0]);
      end
    end
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (seen[s] !== slot_of(rd, 2'(s))) begin
        errors++;
        $display("FAIL abort_slot%0d: got %h expected %h", s, seen[s], slot_of(rd, 2'(s)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_blanking();
    test_overflow();
    test_load_while_busy();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
